// File: rtl/chk_pkg.sv
// Shared types and defaults for the commit_checker end-of-test checker.
package chk_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RF_AW_DEF = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_CHECK,
    ST_PASS,
    ST_FAIL
  } state_t;

  // Expectation entry at the default widths.
  typedef struct packed {
    logic                 en;
    logic [RF_AW_DEF-1:0] reg_idx;
    logic [XLEN_DEF-1:0]  val;
  } entry_t;

  // Index width for an n-entry table; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chk_shadow_rf.sv
// Shadow register file: one write port, one async read port, r0 reads as zero.
module chk_shadow_rf #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             we,
  input  logic [RF_AW-1:0] waddr,
  input  logic [XLEN-1:0]  wdata,
  input  logic [RF_AW-1:0] raddr,
  output logic [XLEN-1:0]  rdata
);

  localparam int DEPTH = 2 ** RF_AW;

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: this array is reset on purpose: a check of a register the core
      // never wrote must see 0, exactly as the real RF comes out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr == '0) ? '0 : mem[raddr];

endmodule

// File: rtl/commit_checker.sv
// End-of-test checker: shadows EXU writebacks, then compares an expectation table
// when the end PC commits. Optional trace output: define COMMIT_CHECKER_TRACE_EN.
module commit_checker
  import chk_pkg::*;
#(
  parameter int NUM_CHECKS  = 4,
  parameter int XLEN        = XLEN_DEF,
  parameter int RF_AW       = RF_AW_DEF,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            cfg_we,
  input  logic [idx_w(NUM_CHECKS)-1:0]    cfg_idx,
  input  logic [RF_AW-1:0]                cfg_reg,
  input  logic [XLEN-1:0]                 cfg_val,
  input  logic                            cfg_en,
  input  logic [XLEN-1:0]                 end_pc,
  input  logic                            start,
  input  logic                            wb_valid,
  input  logic [XLEN-1:0]                 wb_pc,
  input  logic                            wb_rf_we,
  input  logic [RF_AW-1:0]                wb_rf_idx,
  input  logic [XLEN-1:0]                 wb_rf_data,
  output logic                            done,
  output logic                            pass,
  output logic [idx_w(NUM_CHECKS)-1:0]    fail_entry,
  output logic [XLEN-1:0]                 fail_actual,
  output logic                            timeout
);

  localparam int IW = idx_w(NUM_CHECKS);

  typedef struct packed {
    logic             en;
    logic [RF_AW-1:0] reg_idx;
    logic [XLEN-1:0]  val;
  } cfg_entry_t;

  cfg_entry_t      tbl [NUM_CHECKS];
  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            timeout_d;
  logic [IW-1:0]   fail_entry_d;
  logic [XLEN-1:0] fail_actual_d;

  logic            in_snoop;
  logic            rf_we;
  logic            end_hit;
  logic            idx_ok;
  logic            mismatch;
  cfg_entry_t      cur;
  logic [XLEN-1:0] rf_rdata;

  assign in_snoop = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign rf_we    = in_snoop && wb_valid && wb_rf_we;
  assign end_hit  = (state_q == ST_RUN) && wb_valid && (wb_pc == end_pc);
  assign cur      = tbl[ptr_q];
  assign mismatch = cur.en && (rf_rdata != cur.val);

  // The end commit's own write lands this edge; CHECK reads it from the next cycle.
  chk_shadow_rf #(
    .XLEN  (XLEN),
    .RF_AW (RF_AW)
  ) u_shadow_rf (
    .clk    (clk),
    .resetn (resetn),
    .we     (rf_we),
    .waddr  (wb_rf_idx),
    .wdata  (wb_rf_data),
    .raddr  (cur.reg_idx),
    .rdata  (rf_rdata)
  );

  if (NUM_CHECKS == (2 ** IW)) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_part
    assign idx_ok = (32'(cfg_idx) < NUM_CHECKS);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CHECKS; i++) tbl[i] <= '0;
    end else if (cfg_we && (state_q == ST_IDLE) && idx_ok) begin
      tbl[cfg_idx] <= '{en: cfg_en, reg_idx: cfg_reg, val: cfg_val};
    end
  end

  always_comb begin
    // NOTE: every output of this block gets its hold value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    timeout_d     = timeout;
    fail_entry_d  = fail_entry;
    fail_actual_d = fail_actual;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (end_hit) begin
          state_d = ST_CHECK;
          ptr_d   = '0;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == 32'(TIMEOUT_CYC - 1))) begin
          state_d   = ST_FAIL;
          timeout_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          state_d       = ST_FAIL;
          fail_entry_d  = ptr_q;
          fail_actual_d = rf_rdata;
        end else if (ptr_q == IW'(NUM_CHECKS - 1)) begin
          state_d = ST_PASS;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_PASS, ST_FAIL: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      timeout     <= 1'b0;
      fail_entry  <= '0;
      fail_actual <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // the pre-edge values, independent of block ordering.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      timeout     <= timeout_d;
      fail_entry  <= fail_entry_d;
      fail_actual <= fail_actual_d;
    end
  end

  assign done = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign pass = (state_q == ST_PASS);

`ifdef COMMIT_CHECKER_TRACE_EN
  always_ff @(posedge clk) begin
    if (resetn) begin
      if ((state_q == ST_RUN) && wb_valid)
        $display("[chk] pc=%h r%0d<=%h", wb_pc, wb_rf_idx, wb_rf_data);
      if ((state_q == ST_CHECK) && mismatch)
        $display("[chk] entry %0d expected %h actual %h", ptr_q, cur.val, rf_rdata);
      if ((state_q != ST_PASS) && (state_d == ST_PASS))
        $display("\033[32m[chk] ======== TEST PASSED ========\033[0m");
      if ((state_q != ST_FAIL) && (state_d == ST_FAIL))
        $display("\033[31m[chk] ======== TEST FAILED%s ========\033[0m",
                 timeout_d ? " (timeout)" : "");
    end
  end
`else
  // Quiet build: no simulation output.
`endif

endmodule

// File: tb/tb_commit_checker.sv
// Self-checking bench for commit_checker: vector table, directed corner cases,
// and randomized runs scored against a behavioural model.
module tb_commit_checker;

  localparam int N       = 4;
  localparam int TMO     = 50;
  localparam logic [31:0] END_PC = 32'h1c00_00ac;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [4:0]  cfg_reg;
  logic [31:0] cfg_val;
  logic        cfg_en;
  logic [31:0] end_pc;
  logic        start;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_rf_we;
  logic [4:0]  wb_rf_idx;
  logic [31:0] wb_rf_data;
  logic        done;
  logic        pass;
  logic [1:0]  fail_entry;
  logic [31:0] fail_actual;
  logic        timeout;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  commit_checker #(
    .NUM_CHECKS  (N),
    .XLEN        (32),
    .RF_AW       (5),
    .TIMEOUT_CYC (TMO)
  ) u_dut (
    .clk         (clk),
    .resetn      (resetn),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_reg     (cfg_reg),
    .cfg_val     (cfg_val),
    .cfg_en      (cfg_en),
    .end_pc      (end_pc),
    .start       (start),
    .wb_valid    (wb_valid),
    .wb_pc       (wb_pc),
    .wb_rf_we    (wb_rf_we),
    .wb_rf_idx   (wb_rf_idx),
    .wb_rf_data  (wb_rf_data),
    .done        (done),
    .pass        (pass),
    .fail_entry  (fail_entry),
    .fail_actual (fail_actual),
    .timeout     (timeout)
  );

  // Behavioural model: register contents and the expectation table.
  logic [31:0] m_rf  [32];
  logic        m_en  [N];
  logic [4:0]  m_reg [N];
  logic [31:0] m_val [N];

  typedef struct {
    logic [4:0]  wr_reg;
    logic [31:0] wr_val;
    logic [4:0]  ck_reg;
    logic [31:0] ck_val;
    logic        ck_en;
    logic        exp_pass;
    logic [31:0] exp_actual;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    cfg_we   = 1'b0; cfg_idx = '0; cfg_reg = '0; cfg_val = '0; cfg_en = 1'b0;
    start    = 1'b0;
    wb_valid = 1'b0; wb_pc = '0; wb_rf_we = 1'b0; wb_rf_idx = '0; wb_rf_data = '0;
    end_pc   = END_PC;
    step();
    step();
    resetn = 1'b1;
    for (int r = 0; r < 32; r++) m_rf[r] = '0;
    for (int e = 0; e < N; e++) begin
      m_en[e] = 1'b0; m_reg[e] = '0; m_val[e] = '0;
    end
  endtask

  task automatic prog(input int idx, input logic [4:0] rg, input logic [31:0] val, input logic en);
    cfg_we = 1'b1; cfg_idx = idx[1:0]; cfg_reg = rg; cfg_val = val; cfg_en = en;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic we, input logic [4:0] idx,
                        input logic [31:0] data);
    wb_valid = 1'b1; wb_pc = pc; wb_rf_we = we; wb_rf_idx = idx; wb_rf_data = data;
    step();
    wb_valid = 1'b0; wb_rf_we = 1'b0;
    if (we && idx != 5'd0) m_rf[idx] = data;
  endtask

  // End commit, then wait for done and compare the verdict and its latency.
  task automatic finish_run(input string tag, input logic we, input logic [4:0] idx,
                            input logic [31:0] data, input logic exp_pass,
                            input int exp_entry, input logic [31:0] exp_actual);
    int k;
    int exp_lat;
    commit(END_PC, we, idx, data);
    k = 0;
    while (!done && k < 20) begin
      step();
      k++;
    end
    exp_lat = exp_pass ? N : exp_entry + 1;
    check({tag, ".done"},    64'(done),        64'd1);
    check({tag, ".pass"},    64'(pass),        64'(exp_pass));
    check({tag, ".entry"},   64'(fail_entry),  64'(exp_pass ? 0 : exp_entry));
    check({tag, ".actual"},  64'(fail_actual), 64'(exp_actual));
    check({tag, ".timeout"}, 64'(timeout),     64'd0);
    check({tag, ".latency"}, 64'(k),           64'(exp_lat));
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   k;
    int   fidx;
    logic [31:0] fact;
    logic [31:0] sv;

    vecs[0] = '{5'd5, 32'h5a,       5'd5, 32'h5a, 1'b1, 1'b1, 32'h0};
    vecs[1] = '{5'd5, 32'h33,       5'd5, 32'h5a, 1'b1, 1'b0, 32'h33};
    vecs[2] = '{5'd0, 32'hffffffff, 5'd0, 32'h0,  1'b1, 1'b1, 32'h0};
    vecs[3] = '{5'd3, 32'h7,        5'd4, 32'h0,  1'b1, 1'b1, 32'h0};
    vecs[4] = '{5'd3, 32'h7,        5'd3, 32'h8,  1'b0, 1'b1, 32'h0};
    vecs[5] = '{5'd9, 32'h0,        5'd9, 32'h1,  1'b1, 1'b0, 32'h0};

    // Reset state
    do_reset();
    check("reset.done",    64'(done),        64'd0);
    check("reset.pass",    64'(pass),        64'd0);
    check("reset.timeout", 64'(timeout),     64'd0);
    check("reset.entry",   64'(fail_entry),  64'd0);
    check("reset.actual",  64'(fail_actual), 64'd0);

    // Single-entry vectors
    for (int v = 0; v < 6; v++) begin
      do_reset();
      prog(0, vecs[v].ck_reg, vecs[v].ck_val, vecs[v].ck_en);
      start_run();
      commit(32'h1c00_00a8, 1'b1, vecs[v].wr_reg, vecs[v].wr_val);
      finish_run($sformatf("vec%0d", v), 1'b0, 5'd0, 32'h0,
                 vecs[v].exp_pass, 0, vecs[v].exp_actual);
    end

    // Later write overrides the expected value; later traffic is ignored after done
    do_reset();
    prog(0, 5'd5, 32'h5a, 1'b1);
    start_run();
    commit(32'h1c00_00a0, 1'b1, 5'd5, 32'h5a);
    commit(32'h1c00_00a4, 1'b1, 5'd5, 32'h33);
    finish_run("overwrite", 1'b0, 5'd0, 32'h0, 1'b0, 0, 32'h33);
    commit(END_PC, 1'b1, 5'd5, 32'h5a);
    step();
    check("post_done.done",   64'(done),        64'd1);
    check("post_done.pass",   64'(pass),        64'd0);
    check("post_done.actual", 64'(fail_actual), 64'h33);

    // Third entry mismatches
    do_reset();
    prog(0, 5'd1, 32'd1, 1'b1);
    prog(1, 5'd2, 32'd2, 1'b1);
    prog(2, 5'd3, 32'd9, 1'b1);
    start_run();
    commit(32'h1c00_0010, 1'b1, 5'd1, 32'd1);
    commit(32'h1c00_0014, 1'b1, 5'd2, 32'd2);
    commit(32'h1c00_0018, 1'b1, 5'd3, 32'd3);
    finish_run("entry2", 1'b0, 5'd0, 32'h0, 1'b0, 2, 32'd3);

    // Watchdog, and an end commit after it fired is ignored
    do_reset();
    start_run();
    k = 0;
    while (!done && k < 100) begin
      step();
      k++;
    end
    check("wdog.latency", 64'(k),       64'(TMO));
    check("wdog.done",    64'(done),    64'd1);
    check("wdog.timeout", 64'(timeout), 64'd1);
    check("wdog.pass",    64'(pass),    64'd0);
    commit(END_PC, 1'b1, 5'd1, 32'd1);
    step();
    check("wdog.sticky",  64'(timeout), 64'd1);

    // End commit carries the checked register's write
    do_reset();
    prog(0, 5'd7, 32'd7, 1'b1);
    start_run();
    finish_run("same_cycle", 1'b1, 5'd7, 32'd7, 1'b1, 0, 32'h0);

    // Table writes outside IDLE are dropped
    do_reset();
    prog(0, 5'd1, 32'h11, 1'b1);
    start_run();
    prog(0, 5'd1, 32'hdead, 1'b1);
    commit(32'h1c00_0020, 1'b1, 5'd1, 32'h11);
    finish_run("cfg_locked", 1'b0, 5'd0, 32'h0, 1'b1, 0, 32'h0);

    // Reset in CHECK clears everything, including the table
    do_reset();
    prog(3, 5'd1, 32'hbad, 1'b1);
    start_run();
    commit(END_PC, 1'b0, 5'd0, 32'h0);
    check("midchk.busy", 64'(done), 64'd0);
    resetn = 1'b0;
    step();
    check("midchk.done",    64'(done),        64'd0);
    check("midchk.pass",    64'(pass),        64'd0);
    check("midchk.actual",  64'(fail_actual), 64'd0);
    resetn = 1'b1;
    start_run();
    finish_run("empty_table", 1'b0, 5'd0, 32'h0, 1'b1, 0, 32'h0);

    // Randomized runs against the model
    for (int rnd = 0; rnd < 25; rnd++) begin
      int ncom;
      do_reset();
      for (int e = 0; e < N; e++) begin
        m_en[e]  = ($urandom_range(0, 3) != 0);
        m_reg[e] = 5'($urandom_range(0, 3));
        m_val[e] = 32'($urandom_range(0, 3));
        prog(e, m_reg[e], m_val[e], m_en[e]);
      end
      start_run();
      ncom = $urandom_range(0, 15);
      for (int c = 0; c < ncom; c++)
        commit(32'h1c00_0000 + 32'(4 * $urandom_range(0, 40)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
      begin
        logic        ewe;
        logic [4:0]  eidx;
        logic [31:0] edata;
        ewe   = 1'($urandom_range(0, 1));
        eidx  = 5'($urandom_range(0, 3));
        edata = 32'($urandom_range(0, 3));
        // Expected verdict: first enabled entry whose register disagrees
        fidx = -1;
        fact = '0;
        for (int e = 0; e < N; e++) begin
          sv = (m_reg[e] == eidx && ewe && eidx != 0) ? edata : m_rf[m_reg[e]];
          if (fidx < 0 && m_en[e] && sv != m_val[e]) begin
            fidx = e;
            fact = sv;
          end
        end
        finish_run($sformatf("rand%0d", rnd), ewe, eidx, edata,
                   (fidx < 0), (fidx < 0) ? 0 : fidx, fact);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
